dev_bus_host: RTL

- Single-outstanding initiator for the device bus that the memory-mapped peripheral wrappers respond on (req/gnt/addr/we/be/wdata -> rvalid/rdata/err).
- A local client, such as a test sequencer or a DMA-lite engine, issues one command over a valid/ready port and gets one response over a valid/ready port.
- The block drives the bus handshake and bounds every transaction with a timeout.
- It sits between the client logic and the bus crossbar host port.

---
 rtl/dev_bus_pkg.sv | 29 ++
 rtl/dev_bus_host.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dev_bus_pkg.sv
// Shared types for the device-bus host: FSM state encoding plus command and
// response records at the default bus width, for client logic that talks to
// dev_bus_host without overriding its width.
package dev_bus_pkg;

    localparam int unsigned DevBusWidth   = 32;
    localparam int unsigned DevBusBeWidth = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } dev_bus_host_state_e;

    typedef struct packed {
        logic                     we;
        logic [DevBusWidth-1:0]   addr;
        logic [DevBusBeWidth-1:0] be;
        logic [DevBusWidth-1:0]   wdata;
    } dev_bus_cmd_t;

    typedef struct packed {
        logic [DevBusWidth-1:0] rdata;
        logic                   err;
        logic                   timeout;
    } dev_bus_rsp_t;

endpackage

// File: rtl/dev_bus_host.sv
// Single-outstanding device-bus initiator. Accepts one command from a local
// client, runs the req/gnt then rvalid handshake on the bus, and returns one
// response. Every transaction is bounded by a REQ+WAIT cycle budget; a
// transaction that runs out of budget is answered with err and timeout set.
module dev_bus_host
    import dev_bus_pkg::*;
#(
    parameter int unsigned BusWidth      = DevBusWidth,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_we_i,
    input  logic [BusWidth-1:0]      cmd_addr_i,
    input  logic [DevBusBeWidth-1:0] cmd_be_i,
    input  logic [BusWidth-1:0]      cmd_wdata_i,

    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [BusWidth-1:0]      rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic                     rsp_timeout_o,

    output logic                     host_req_o,
    input  logic                     host_gnt_i,
    output logic [BusWidth-1:0]      host_addr_o,
    output logic                     host_we_o,
    output logic [DevBusBeWidth-1:0] host_be_o,
    output logic [BusWidth-1:0]      host_wdata_o,
    input  logic                     host_rvalid_i,
    input  logic [BusWidth-1:0]      host_rdata_i,
    input  logic                     host_err_i,

    output logic                     busy_o
);

    // Same shape as the package records, but sized by this instance's width.
    typedef struct packed {
        logic                     we;
        logic [BusWidth-1:0]      addr;
        logic [DevBusBeWidth-1:0] be;
        logic [BusWidth-1:0]      wdata;
    } cmd_t;

    typedef struct packed {
        logic [BusWidth-1:0] rdata;
        logic                err;
        logic                timeout;
    } rsp_t;

    dev_bus_host_state_e state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    rsp_t                rsp_q, rsp_d;

    logic cmd_accept;
    logic in_flight;
    logic timeout_hit;

    assign cmd_accept = (state_q == IDLE) && cmd_valid_i;
    assign in_flight  = (state_q == REQ) || (state_q == WAIT);

    if (TimeoutCycles > 0) begin : g_timeout
        localparam int unsigned CountWidth = $clog2(TimeoutCycles + 1);
        localparam logic [CountWidth-1:0] CountLast = CountWidth'(TimeoutCycles - 1);

        logic [CountWidth-1:0] count_q;

        // Budget counter: restarts on each accepted command, runs while on the bus.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                count_q <= '0;
            end else if (cmd_accept) begin
                count_q <= '0;
            end else if (in_flight) begin
                count_q <= count_q + CountWidth'(1);
            end
        end

        assign timeout_hit = in_flight && (count_q == CountLast);
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

    // State, command and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rsp_q   <= rsp_d;
        end
    end

    // Next state plus register loads; a grant or rvalid in the expiry cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rsp_d   = rsp_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    cmd_d.we    = cmd_we_i;
                    cmd_d.addr  = {cmd_addr_i[BusWidth-1:2], 2'b00};
                    cmd_d.be    = cmd_be_i;
                    cmd_d.wdata = cmd_wdata_i;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (host_gnt_i) begin
                    state_d = WAIT;
                end else if (timeout_hit) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    state_d       = RESP;
                end
            end
            WAIT: begin
                if (host_rvalid_i) begin
                    rsp_d.rdata   = cmd_q.we ? '0 : host_rdata_i;
                    rsp_d.err     = host_err_i;
                    rsp_d.timeout = 1'b0;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);

    assign host_req_o    = (state_q == REQ);
    assign host_addr_o   = cmd_q.addr;
    assign host_we_o     = cmd_q.we;
    assign host_be_o     = cmd_q.be;
    assign host_wdata_o  = cmd_q.wdata;

    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_rdata_o   = rsp_q.rdata;
    assign rsp_err_o     = rsp_q.err;
    assign rsp_timeout_o = rsp_q.timeout;

endmodule
